// File: rtl/aec.sv
// aec: streaming infix calculator with parenthesis check (shunting-yard then postfix evaluation)
module aec #(
    parameter int MAX_LEN = 16,
    parameter int DW = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ready,
    input  logic [7:0] ascii_in,
    output logic       valid,
    output logic [6:0] result,
    output logic       parenthesesLegal
);
    localparam int SW = $clog2(MAX_LEN + 1);
    typedef enum logic [1:0] {IDLE, RECV, EVAL, DONE} state_t;
    state_t state, nxt;
    logic [1:0] ostk [2**SW];
    logic [4:0] q [2**SW];
    logic signed [DW-1:0] vs [2**SW];
    logic [SW-1:0] sp, qcnt, depth, e, vp;
    logic ill;
    logic acc, ill_b, ill_n, leg;
    logic [SW-1:0] sp_b, qn, d_b, sp_pop, sp_n, qn_n, d_n;
    logic is_num, is_dig, is_add, is_sub, is_mul, is_lp, is_rp, is_eq, is_pop;
    logic [3:0] dval;
    logic [1:0] t0, t1, opc;
    logic n0, n1, lp_pop, push, w0;
    logic [4:0] tk0, tk1, tk;
    logic signed [DW-1:0] a, b, alu, nv;
    logic [SW-1:0] vidx, vp_n;
    logic last;
    // Operator codes on the stack: 0 '+', 1 '-', 2 '*', 3 '('; tokens carry bit 4 set for operators.
    always_comb begin
        acc = ready || state == RECV;
        sp_b = ready ? '0 : sp;
        qn = ready ? '0 : qcnt;
        d_b = ready ? '0 : depth;
        ill_b = ready ? 1'b0 : ill;
        is_num = ascii_in >= "0" && ascii_in <= "9";
        is_dig = is_num || (ascii_in >= "a" && ascii_in <= "f");
        is_add = ascii_in == "+";
        is_sub = ascii_in == "-";
        is_mul = ascii_in == "*";
        is_lp = ascii_in == "(";
        is_rp = ascii_in == ")";
        is_eq = ascii_in == "=";
        dval = 4'(is_num ? ascii_in - 8'h30 : ascii_in - 8'h57);
        opc = is_mul ? 2'd2 : is_sub ? 2'd1 : is_lp ? 2'd3 : 2'd0;
        t0 = ostk[sp_b - SW'(1)];
        t1 = ostk[sp_b - SW'(2)];
        // Each paren level holds at most [+/-][*], so two pops per character always suffice.
        is_pop = is_add || is_sub || is_rp || is_eq;
        n0 = sp_b != '0 && (is_pop ? t0 != 2'd3 : is_mul && t0 == 2'd2);
        n1 = is_pop && n0 && sp_b > SW'(1) && t1 != 2'd3;
        lp_pop = is_rp && d_b != '0;
        push = is_add || is_sub || is_mul || is_lp;
        w0 = is_dig || n0;
        tk0 = is_dig ? {1'b0, dval} : {3'b100, t0};
        tk1 = {3'b100, t1};
        sp_pop = sp_b - SW'(n0) - SW'(n1) - SW'(lp_pop);
        sp_n = sp_pop + SW'(push);
        qn_n = qn + SW'(w0) + SW'(n1);
        d_n = is_lp ? d_b + SW'(1) : lp_pop ? d_b - SW'(1) : d_b;
        ill_n = ill_b || (is_rp && d_b == '0);
        leg = !ill_b && d_b == '0;
        tk = q[e];
        b = vs[vp - SW'(1)];
        a = vs[vp - SW'(2)];
        alu = tk[1:0] == 2'd2 ? a * b : tk[0] ? a - b : a + b;
        nv = tk[4] ? alu : DW'(tk[3:0]);
        vidx = tk[4] ? vp - SW'(2) : vp;
        vp_n = tk[4] ? vp - SW'(1) : vp + SW'(1);
        last = e + SW'(1) >= qcnt;
    end
    always_comb begin
        nxt = state;
        if (acc)
            nxt = is_eq ? (leg ? EVAL : DONE) : RECV;
        else if (state == EVAL)
            nxt = last ? DONE : EVAL;
        else if (state == DONE)
            nxt = IDLE;
    end
    always_comb valid = state == DONE;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sp <= '0;
            qcnt <= '0;
            depth <= '0;
            e <= '0;
            vp <= '0;
            ill <= 1'b0;
            result <= '0;
            parenthesesLegal <= 1'b0;
        end else begin
            state <= nxt;
            if (acc) begin
                if (w0) q[qn] <= tk0;
                if (n1) q[qn + SW'(w0)] <= tk1;
                if (push) ostk[sp_pop] <= opc;
                sp <= sp_n;
                qcnt <= qn_n;
                depth <= d_n;
                ill <= ill_n;
                e <= '0;
                vp <= '0;
                if (is_eq && !leg) begin
                    result <= '0;
                    parenthesesLegal <= 1'b0;
                end
            end else if (state == EVAL) begin
                vs[vidx] <= nv;
                vp <= vp_n;
                e <= e + SW'(1);
                if (last) begin
                    result <= nv[6:0];
                    parenthesesLegal <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_aec.sv
// tb_aec: random and directed expressions checked against a level-stack evaluator
module tb_aec;
    localparam int ML = 16;
    logic clk = 1'b0;
    logic rst, ready, valid, parenthesesLegal;
    logic [7:0] ascii_in;
    logic [6:0] result;
    int n_chk = 0, n_pass = 0, n_valid = 0, exp_valid = 0;
    logic [7:0] ex [ML];
    int elen;
    aec #(.MAX_LEN(ML), .DW(16)) dut (
        .clk(clk),
        .rst(rst),
        .ready(ready),
        .ascii_in(ascii_in),
        .valid(valid),
        .result(result),
        .parenthesesLegal(parenthesesLegal)
    );
    always #5 clk = ~clk;
    always @(negedge clk) if (valid) n_valid++;
    task automatic chk(input string tag, input int got, input int expv);
        n_chk++;
        if (got !== expv) $display("FAIL %s got %0d expected %0d", tag, got, expv);
        else n_pass++;
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic load(input string s);
        elen = s.len();
        for (int i = 0; i < elen; i++) ex[i] = s[i];
    endtask
    // Each paren level keeps a running sum, pending sign, current product and a pending '*'.
    function automatic void model(output int leg, output int val);
        int d = 0, lv = 0, v = 0;
        bit il = 0, hv;
        int sm [ML+1], pr [ML+1], sg [ML+1];
        bit mp [ML+1];
        logic [7:0] c;
        sm[0] = 0; pr[0] = 0; sg[0] = 1; mp[0] = 0;
        for (int i = 0; i < elen && ex[i] != "="; i++) begin
            c = ex[i];
            hv = 0;
            if (c >= "0" && c <= "9") begin v = int'(c) - 48; hv = 1; end
            else if (c >= "a" && c <= "f") begin v = int'(c) - 87; hv = 1; end
            else if (c == "(") begin
                d++; lv++;
                sm[lv] = 0; pr[lv] = 0; sg[lv] = 1; mp[lv] = 0;
            end else if (c == ")") begin
                if (d == 0) il = 1;
                else begin d--; v = sm[lv] + sg[lv] * pr[lv]; lv--; hv = 1; end
            end else if (c == "*") mp[lv] = 1;
            else if (c == "+" || c == "-") begin
                sm[lv] += sg[lv] * pr[lv];
                sg[lv] = (c == "+") ? 1 : -1;
                pr[lv] = 0;
            end
            if (hv) begin pr[lv] = mp[lv] ? pr[lv] * v : v; mp[lv] = 0; end
        end
        leg = (!il && d == 0) ? 1 : 0;
        val = leg ? (sm[0] + sg[0] * pr[0]) & 127 : 0;
    endfunction
    task automatic feed();
        for (int i = 0; i < elen; i++) begin
            ready = (i == 0);
            ascii_in = ex[i];
            step();
        end
        ready = 1'b0;
        ascii_in = "=";
    endtask
    task automatic run(input string tag, input int leg, input int val, input bit chk_res);
        int n = 0;
        feed();
        while (!valid && n < ML + 4) begin step(); n++; end
        chk({tag, "_valid"}, int'(valid), 1);
        exp_valid++;
        chk({tag, "_legal"}, int'(parenthesesLegal), leg);
        if (leg == 0) chk({tag, "_res0"}, int'(result), 0);
        else if (chk_res) chk({tag, "_res"}, int'(result), val);
        step();
        chk({tag, "_pulse"}, int'(valid), 0);
    endtask
    task automatic gen(output bit wf);
        int d = 0, n = 0, k, pos;
        bit go = 1;
        wf = 1;
        while (go) begin
            if ($urandom % 3 == 0) begin ex[n] = 8'h28; n++; d++; end
            k = $urandom % 16;
            ex[n] = 8'(k < 10 ? 48 + k : 87 + k); n++;
            if (d > 0 && $urandom % 3 == 0) begin ex[n] = 8'h29; n++; d--; end
            go = (n + d <= 9) && ($urandom % 4 != 0);
            if (go) begin
                k = $urandom % 3;
                ex[n] = k == 0 ? 8'h2b : k == 1 ? 8'h2d : 8'h2a;
                n++;
            end
        end
        while (d > 0) begin ex[n] = 8'h29; n++; d--; end
        k = $urandom % 4;
        if (k == 0) begin
            pos = $urandom % n;
            ex[pos] = ($urandom % 2) ? 8'h29 : 8'h28;
            wf = 0;
        end else if (k == 1) begin
            pos = $urandom_range(0, n);
            for (int j = n; j > pos; j--) ex[j] = ex[j-1];
            k = $urandom % 4;
            ex[pos] = k == 0 ? 8'h20 : k == 1 ? 8'h78 : k == 2 ? 8'h67 : 8'h3f;
            n++;
        end
        ex[n] = 8'h3d;
        elen = n + 1;
    endtask
    initial begin
        int leg, val;
        bit wf;
        rst = 1'b1; ready = 1'b0; ascii_in = 8'h00;
        step(); step();
        rst = 1'b0;
        chk("rst_valid", int'(valid), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_legal", int'(parenthesesLegal), 0);
        load("1+2*3="); run("prec", 1, 7, 1);
        load("(1+2)*3="); run("paren", 1, 9, 1);
        load("a*(b-3)="); run("hex", 1, 80, 1);
        load("(1+2))*3="); run("extra_close", 0, 0, 1);
        load("((4+5)="); run("unclosed", 0, 0, 1);
        load(")1+2(="); run("early_close", 0, 0, 1);
        load("1+2*3="); run("hold_a", 1, 7, 1);
        for (int i = 0; i < 20; i++) step();
        chk("hold_result", int'(result), 7);
        chk("hold_legal", int'(parenthesesLegal), 1);
        load("f-5*2="); run("b2b", 1, 5, 1);
        load("1+(2");
        feed();
        rst = 1'b1; step(); rst = 1'b0;
        chk("midrst_result", int'(result), 0);
        chk("midrst_legal", int'(parenthesesLegal), 0);
        for (int i = 0; i < 4; i++) step();
        chk("midrst_novalid", int'(valid), 0);
        load("2*(3+4)="); run("after_rst", 1, 14, 1);
        load("3+4*");
        feed();
        load("5*5-7="); run("abort", 1, 18, 1);
        load("9*9*9-1="); run("wrap", 1, 728 & 127, 1);
        for (int t = 0; t < 60; t++) begin
            gen(wf);
            model(leg, val);
            run("rand", leg, val, wf);
            if ($urandom % 2) step();
        end
        for (int i = 0; i < 3; i++) step();
        chk("valid_count", n_valid, exp_valid);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
